data_memory_ctrl: RTL and testbench

Parametrised data memory for the datapath, the successor to the fixed 16-bit memwrite/memread data memory.
- Adds a request/ready handshake, configurable wait states, byte-enable writes, registered read data, and an error response for misaligned or out-of-range accesses.
- Sits between the datapath/load-store control and the storage array.
- Services one request at a time.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_array.sv | 30 +++
 rtl/data_memory_ctrl.sv | 139 +++++++++++++
 tb/tb_data_memory_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and width helpers for the data memory controller and its storage array.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int bytes_f(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int offset_w_f(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Counter only ever holds WAIT_CYCLES-1 down to 0; keep at least one bit.
  function automatic int cnt_w_f(input int wait_cycles);
    return (wait_cycles < 2) ? 1 : $clog2(wait_cycles);
  endfunction

  function automatic int idx_w_f(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with synchronous byte-enable write and registered read; no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [bytes_f(DATA_W)-1:0]  be,
  input  logic                        re,
  input  logic [idx_w_f(DEPTH)-1:0]   addr,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           rdata
);

  localparam int BYTES = bytes_f(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Request/response data memory controller: address checking, wait-state FSM, byte-enable
// writes and registered read data in front of a dmem_array.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           write_data,
  input  logic [bytes_f(DATA_W)-1:0]  byte_en,
  output logic                        resp_valid,
  output logic [DATA_W-1:0]           read_data,
  output logic                        resp_err
);

  localparam int BYTES    = bytes_f(DATA_W);
  localparam int OFFSET_W = offset_w_f(DATA_W);
  localparam int CNT_W    = cnt_w_f(WAIT_CYCLES);
  localparam int AW       = idx_w_f(DEPTH);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic              write_q, err_q;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BYTES-1:0]  be_q;

  logic              resp_err_q, rd_mem_q;
  logic [DATA_W-1:0] arr_rdata;

  logic [ADDR_W-1:0] idx_in;
  logic              err_in;
  logic              accept, commit;

  logic              cur_write, cur_err;
  logic [AW-1:0]     cur_idx;
  logic [DATA_W-1:0] cur_wdata;
  logic [BYTES-1:0]  cur_be;

  assign idx_in = addr >> OFFSET_W;
  assign err_in = ((addr & OFF_MASK) != '0) || ({1'b0, idx_in} >= DEPTH_X);

  assign accept = (state_q == IDLE) && req_valid;

  // With no wait states the array access happens on the accept edge, straight from the ports.
  assign commit = ((state_q == WAIT) && (cnt_q == '0)) || (accept && (WAIT_CYCLES == 0));

  always_comb begin
    if (WAIT_CYCLES == 0) begin
      cur_write = req_write;
      cur_err   = err_in;
      cur_idx   = idx_in[AW-1:0];
      cur_wdata = write_data;
      cur_be    = byte_en;
    end else begin
      cur_write = write_q;
      cur_err   = err_q;
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt_q == '0) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_err_q;
  assign read_data  = rd_mem_q ? arr_rdata : '0;

  // Control state: FSM, wait counter, latched request kind and response flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      resp_err_q <= 1'b0;
      rd_mem_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= CNT_LOAD;
        write_q <= req_write;
        err_q   <= err_in;
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (commit) begin
        resp_err_q <= cur_err;
        rd_mem_q   <= !cur_write && !cur_err;
      end
    end
  end

  // Request payload latch
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= idx_in[AW-1:0];
      wdata_q <= write_data;
      be_q    <= byte_en;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (commit && cur_write && !cur_err),
    .be    (cur_be),
    .re    (commit && !cur_write && !cur_err),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed scoreboard bench for data_memory_ctrl with WAIT_CYCLES = 1, 3 and 0 instances.
module tb_data_memory_ctrl;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]       req_valid, req_ready, req_write, resp_valid, resp_err;
  logic [2:0][15:0] addr, write_data, read_data;
  logic [2:0][1:0]  byte_en;

  logic [15:0] ref_mem [3][1024];
  exp_t        sb [$];
  int          n_assert = 0;
  int          n_fail   = 0;

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .addr(addr[0]), .write_data(write_data[0]),
    .byte_en(byte_en[0]), .resp_valid(resp_valid[0]), .read_data(read_data[0]),
    .resp_err(resp_err[0]));

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .addr(addr[1]), .write_data(write_data[1]),
    .byte_en(byte_en[1]), .resp_valid(resp_valid[1]), .read_data(read_data[1]),
    .resp_err(resp_err[1]));

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .addr(addr[2]), .write_data(write_data[2]),
    .byte_en(byte_en[2]), .resp_valid(resp_valid[2]), .read_data(read_data[2]),
    .resp_err(resp_err[2]));

  function automatic int wc_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input int d, input logic wr, input logic [15:0] a,
                       input logic [15:0] wd, input logic [1:0] be, output exp_t e);
    int w;
    w = int'(a >> 1);
    e.err = a[0] | (w >= 1024);
    if (wr) begin
      e.data = 16'h0000;
      if (!e.err) begin
        if (be[0]) ref_mem[d][w][7:0]  = wd[7:0];
        if (be[1]) ref_mem[d][w][15:8] = wd[15:8];
      end
    end else begin
      e.data = e.err ? 16'h0000 : ref_mem[d][w];
    end
  endtask

  task automatic do_req(input int d, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [1:0] be, input string tag);
    exp_t e, g;
    int n, lat, lo;
    req_valid[d] = 1'b1; req_write[d] = wr; addr[d] = a; write_data[d] = wd; byte_en[d] = be;
    n = 0;
    while (!req_ready[d] && n < 50) begin tick(); n++; end
    chk({tag, " ready"}, 32'(req_ready[d]), 32'd1);
    tick();
    req_valid[d] = 1'b0;
    model(d, wr, a, wd, be, e);
    sb.push_back(e);
    lat = 1;
    lo  = req_ready[d] ? 0 : 1;
    while (!resp_valid[d] && lat <= 20) begin
      tick(); lat++;
      if (!req_ready[d]) lo++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(wc_of(d) + 1));
    chk({tag, " ready_low"}, 32'(lo), 32'(wc_of(d) + 1));
    g = sb.pop_front();
    chk({tag, " data"}, 32'(read_data[d]), 32'(g.data));
    chk({tag, " err"}, 32'(resp_err[d]), 32'(g.err));
    tick();
    chk({tag, " valid_drop"}, 32'(resp_valid[d]), 32'd0);
    chk({tag, " data_hold"}, 32'(read_data[d]), 32'(g.data));
    chk({tag, " err_hold"}, 32'(resp_err[d]), 32'(g.err));
    chk({tag, " ready_back"}, 32'(req_ready[d]), 32'd1);
  endtask

  initial begin : main
    int cyc, last, acc_n, wait_n, n;
    logic wr, acc;
    logic [15:0] v;
    exp_t e, g;

    rst = 1'b1;
    req_valid = '0; req_write = '0; addr = '0; write_data = '0; byte_en = '0;
    tick();
    for (int d = 0; d < 3; d++) begin
      chk("reset ready", 32'(req_ready[d]), 32'd1);
      chk("reset valid", 32'(resp_valid[d]), 32'd0);
      chk("reset data", 32'(read_data[d]), 32'd0);
      chk("reset err", 32'(resp_err[d]), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Basic write/read and partial writes
    do_req(0, 1'b1, 16'h0000, 16'h1357, 2'b11, "w_word0");
    do_req(0, 1'b1, 16'h0010, 16'h0C02, 2'b11, "s1_write");
    do_req(0, 1'b0, 16'h0010, 16'h0000, 2'b00, "s1_read");
    do_req(0, 1'b1, 16'h0010, 16'hAAFF, 2'b01, "s2_write_lo");
    do_req(0, 1'b0, 16'h0010, 16'h0000, 2'b11, "s2_read");
    do_req(0, 1'b1, 16'h0010, 16'hFFFF, 2'b00, "be_zero_write");
    do_req(0, 1'b0, 16'h0010, 16'h0000, 2'b11, "be_zero_read");
    do_req(0, 1'b1, 16'h0012, 16'h9A00, 2'b10, "hi_byte_write");
    do_req(0, 1'b0, 16'h0012, 16'h0000, 2'b11, "hi_byte_read");

    // Error responses and boundary word
    do_req(0, 1'b1, 16'h07FE, 16'h7E7E, 2'b11, "last_word_write");
    do_req(0, 1'b0, 16'h0005, 16'h0000, 2'b11, "s3_misaligned");
    do_req(0, 1'b1, 16'h0800, 16'h1234, 2'b11, "s3_out_of_range");
    do_req(0, 1'b1, 16'h0011, 16'h4321, 2'b11, "misaligned_write");
    do_req(0, 1'b0, 16'h0000, 16'h0000, 2'b11, "s3_word0_intact");
    do_req(0, 1'b0, 16'h0010, 16'h0000, 2'b11, "s3_word8_intact");
    do_req(0, 1'b0, 16'h07FE, 16'h0000, 2'b11, "last_word_read");

    // Wait-state variants
    do_req(1, 1'b1, 16'h0004, 16'hBEEF, 2'b11, "wc3_write");
    do_req(1, 1'b0, 16'h0004, 16'h0000, 2'b11, "wc3_read");
    do_req(2, 1'b1, 16'h0004, 16'h1234, 2'b11, "wc0_write");
    do_req(2, 1'b0, 16'h0004, 16'h0000, 2'b11, "wc0_read");
    do_req(2, 1'b0, 16'h0003, 16'h0000, 2'b11, "wc0_misaligned");

    // Reset in the middle of a pending write
    do_req(0, 1'b1, 16'h0020, 16'h1111, 2'b11, "s5_pre_write");
    req_valid[0] = 1'b1; req_write[0] = 1'b1; addr[0] = 16'h0020;
    write_data[0] = 16'h5555; byte_en[0] = 2'b11;
    n = 0;
    while (!req_ready[0] && n < 50) begin tick(); n++; end
    tick();
    req_valid[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("s5 rst ready", 32'(req_ready[0]), 32'd1);
    chk("s5 rst valid", 32'(resp_valid[0]), 32'd0);
    chk("s5 rst data", 32'(read_data[0]), 32'd0);
    chk("s5 rst err", 32'(resp_err[0]), 32'd0);
    tick();
    chk("s5 rst valid2", 32'(resp_valid[0]), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5 no_resp", 32'(resp_valid[0]), 32'd0);
    end
    do_req(0, 1'b0, 16'h0020, 16'h0000, 2'b11, "s5_read_old");

    // Continuous requests alternating write/read on word 0
    cyc = 0; last = 0; acc_n = 0;
    wr = 1'b1; v = 16'h0101;
    req_valid[0] = 1'b1; req_write[0] = wr; addr[0] = 16'h0000;
    write_data[0] = v; byte_en[0] = 2'b11;
    while (acc_n < 8 && cyc < 100) begin
      acc = req_ready[0];
      if (resp_valid[0] && sb.size() > 0) begin
        g = sb.pop_front();
        chk("s6 data", 32'(read_data[0]), 32'(g.data));
        chk("s6 err", 32'(resp_err[0]), 32'(g.err));
      end
      tick();
      cyc++;
      if (acc) begin
        if (acc_n > 0) chk("s6 gap", 32'(cyc - last), 32'd3);
        last = cyc;
        acc_n++;
        model(0, wr, 16'h0000, v, 2'b11, e);
        sb.push_back(e);
        if (!wr) v = v + 16'h1111;
        wr = !wr;
        req_write[0] = wr;
        write_data[0] = v;
      end
    end
    req_valid[0] = 1'b0;
    chk("s6 accepts", 32'(acc_n), 32'd8);
    wait_n = 0;
    while (!resp_valid[0] && wait_n < 20) begin tick(); wait_n++; end
    chk("s6 final resp", 32'(resp_valid[0]), 32'd1);
    if (sb.size() > 0) begin
      g = sb.pop_front();
      chk("s6 final data", 32'(read_data[0]), 32'(g.data));
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
